// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with bit gating, frame abort, overrun detection
// and a valid/ready output register. Define SIPO_PARITY_EN to append an even-parity bit to each frame.
module sipo_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             clear,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   output logic             parity_err,
   output logic             busy
);

   // Handshake: a word moves downstream on any rising edge where dout_valid and
   // dout_ready are both 1; dout is held unchanged while valid is high without ready.

`ifdef SIPO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CW = $clog2(FRAME + 1);

`ifdef SIPO_PARITY_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1} state_t;
`endif

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overrun_q, overrun_d;
   logic             parity_err_q, parity_err_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] word;
   logic             word_perr;
   logic             complete;
   logic             transfer;

   always_comb begin
      shifted   = LSB_FIRST ? {sin, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], sin};
      state_d   = state_q;
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      word      = shifted;
      word_perr = 1'b0;
      complete  = 1'b0;

      // clear wins over sin_valid: the bit offered on the same edge is dropped
      if (clear) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         sr_d    = '0;
      end else if (sin_valid) begin
         case (state_q)
            S_IDLE: begin
               sr_d    = shifted;
               cnt_d   = CW'(1);
               state_d = S_RECV;
            end
            S_RECV: begin
               sr_d  = shifted;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                  state_d = S_PARITY;
`else
                  complete = 1'b1;
                  cnt_d    = '0;
                  state_d  = S_IDLE;
`endif
               end
            end
`ifdef SIPO_PARITY_EN
            S_PARITY: begin
               // the parity bit closes the frame but never enters the data word
               word      = sr_q;
               word_perr = (^sr_q) ^ sin;
               complete  = 1'b1;
               cnt_d     = '0;
               state_d   = S_IDLE;
            end
`endif
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      transfer     = dout_valid_q & dout_ready;
      dout_d       = dout_q;
      parity_err_d = parity_err_q;
      dout_valid_d = dout_valid_q & ~transfer;
      overrun_d    = 1'b0;
      if (complete) begin
         if (!dout_valid_q || transfer) begin
            dout_d       = word;
            parity_err_d = word_perr;
            dout_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
      busy_d = (cnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         sr_q         <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         parity_err_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
         parity_err_q <= parity_err_d;
         busy_q       <= busy_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign overrun    = overrun_q;
   assign parity_err = parity_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: two instances (LSB-first and MSB-first) share one serial stream;
// expected words are queued at stimulus time and checked by a monitor on each output transfer.
module tb_sipo_deserializer;

   localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst, sin, sin_valid, clear, dout_ready;
   logic [WIDTH-1:0] dout_a, dout_b;
   logic             dout_valid_a, dout_valid_b;
   logic             overrun_a, overrun_b;
   logic             parity_err_a, parity_err_b;
   logic             busy_a, busy_b;

   logic [WIDTH:0] exp_qa[$];
   logic [WIDTH:0] exp_qb[$];
   int total = 0;
   int bad   = 0;
   int ovr_a = 0;
   int ovr_b = 0;

   // clock / reset
   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
      .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready),
      .overrun(overrun_a), .parity_err(parity_err_a), .busy(busy_a)
   );

   sipo_deserializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
      .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready),
      .overrun(overrun_b), .parity_err(parity_err_b), .busy(busy_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst && dout_valid_a && dout_ready) begin
         if (exp_qa.size() == 0) begin
            total++;
            bad++;
            $display("FAIL word_a: got %h want nothing", {parity_err_a, dout_a});
         end else begin
            chk("word_a", 32'({parity_err_a, dout_a}), 32'(exp_qa.pop_front()));
         end
      end
      if (!rst && dout_valid_b && dout_ready) begin
         if (exp_qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL word_b: got %h want nothing", {parity_err_b, dout_b});
         end else begin
            chk("word_b", 32'({parity_err_b, dout_b}), 32'(exp_qb.pop_front()));
         end
      end
      if (overrun_a) ovr_a++;
      if (overrun_b) ovr_b++;
   end

   // driver tasks
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      sin       = b;
      sin_valid = 1'b1;
      @(posedge clk);
      #1;
      sin_valid = 1'b0;
      sin       = 1'b0;
   endtask

   function automatic logic frame_bit(input logic [WIDTH-1:0] d, input logic p, input int i);
      return (i < WIDTH) ? d[i] : p;
   endfunction

   // d is sent bit 0 first; exp_b is d as the MSB-first instance assembles it
   task automatic send_frame(input logic [WIDTH-1:0] d, input logic p, input logic [WIDTH-1:0] exp_b,
                             input logic exp_err, input bit push);
      if (push) begin
         exp_qa.push_back({exp_err, d});
         exp_qb.push_back({exp_err, exp_b});
      end
      for (int i = 0; i < FRAME; i++) send_bit(frame_bit(d, p, i));
   endtask

   initial begin
      rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; clear = 1'b0; dout_ready = 1'b1;
      idle(2);
      chk("rst_dout", 32'(dout_a), 32'h0);
      chk("rst_valid", 32'(dout_valid_a), 32'h0);
      chk("rst_overrun", 32'(overrun_a), 32'h0);
      chk("rst_perr", 32'(parity_err_a), 32'h0);
      chk("rst_busy", 32'({busy_a, busy_b}), 32'h0);
      rst = 1'b0;
      idle(1);

      // 0xA5, continuous bits: busy through the frame, one-cycle valid pulse
      exp_qa.push_back({1'b0, 8'hA5});
      exp_qb.push_back({1'b0, 8'hA5});
      for (int i = 0; i < FRAME; i++) begin
         send_bit(frame_bit(8'hA5, 1'b0, i));
         if (i < FRAME - 1) begin
            chk("a5_busy", 32'(busy_a), 32'h1);
            chk("a5_valid_early", 32'(dout_valid_a), 32'h0);
         end else begin
            chk("a5_valid", 32'({dout_valid_a, dout_valid_b}), 32'h3);
            chk("a5_busy_end", 32'(busy_a), 32'h0);
            chk("a5_dout", 32'(dout_a), 32'hA5);
         end
      end
      idle(1);
      chk("a5_valid_drop", 32'(dout_valid_a), 32'h0);

      // bit order
      send_frame(8'h01, 1'b1, 8'h80, 1'b0, 1'b1);
      idle(1);

      // 0x3C with random gaps
      exp_qa.push_back({1'b0, 8'h3C});
      exp_qb.push_back({1'b0, 8'h3C});
      for (int i = 0; i < FRAME; i++) begin
         send_bit(frame_bit(8'h3C, 1'b0, i));
         if (i < FRAME - 1) begin
            repeat ($urandom_range(0, 3)) begin
               idle(1);
               chk("gap_busy", 32'({busy_a, busy_b}), 32'h3);
            end
         end
      end
      idle(1);

      // overrun: 0x12 held, 0x34 dropped
      dout_ready = 1'b0;
      send_frame(8'h12, 1'b0, 8'h48, 1'b0, 1'b1);
      chk("ovr_none_yet", 32'(overrun_a), 32'h0);
      send_frame(8'h34, 1'b1, 8'h2C, 1'b0, 1'b0);
      chk("ovr_pulse", 32'({overrun_a, overrun_b}), 32'h3);
      chk("ovr_hold_a", 32'(dout_a), 32'h12);
      chk("ovr_hold_b", 32'(dout_b), 32'h48);
      idle(1);
      chk("ovr_one_cycle", 32'(overrun_a), 32'h0);
      chk("ovr_still_held", 32'(dout_a), 32'h12);
      dout_ready = 1'b1;
      idle(1);
      dout_ready = 1'b0;
      chk("ovr_valid_drop", 32'({dout_valid_a, dout_valid_b}), 32'h0);
      dout_ready = 1'b1;

      // clear with sin_valid on the same edge, then a full frame
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      chk("clr_busy_before", 32'(busy_a), 32'h1);
      clear = 1'b1; sin = 1'b1; sin_valid = 1'b1;
      idle(1);
      clear = 1'b0; sin = 1'b0; sin_valid = 1'b0;
      chk("clr_busy_after", 32'({busy_a, busy_b}), 32'h0);
      send_frame(8'h5A, 1'b0, 8'h5A, 1'b0, 1'b1);
      idle(2);

      // reset mid-frame while a word is held
      dout_ready = 1'b0;
      send_frame(8'hC3, 1'b0, 8'hC3, 1'b0, 1'b0);
      chk("pre_rst_valid", 32'(dout_valid_a), 32'h1);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      chk("pre_rst_busy", 32'(busy_a), 32'h1);
      rst = 1'b1;
      idle(1);
      chk("mid_rst_dout", 32'({dout_a, dout_b}), 32'h0);
      chk("mid_rst_flags", 32'({dout_valid_a, dout_valid_b, overrun_a, busy_a, busy_b, parity_err_a}), 32'h0);
      rst = 1'b0;
      dout_ready = 1'b1;
      idle(1);

`ifdef SIPO_PARITY_EN
      send_frame(8'h07, 1'b1, 8'hE0, 1'b0, 1'b1);
      idle(1);
      send_frame(8'h07, 1'b0, 8'hE0, 1'b1, 1'b1);
      idle(1);
`endif

      idle(2);
      chk("queue_a_empty", 32'(exp_qa.size()), 32'h0);
      chk("queue_b_empty", 32'(exp_qb.size()), 32'h0);
      chk("overrun_count_a", 32'(ovr_a), 32'h1);
      chk("overrun_count_b", 32'(ovr_b), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
